// File: rtl/pipe_addsub_nbit.sv
// pipe_addsub_nbit
//   Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into SEG_W-bit
//   segments with one register stage per segment (STAGES = WIDTH/SEG_W).
//   Operand bits that are still unresolved ride along in skew registers. The
//   result segments that are already resolved are held in deskew registers, so
//   OUT leaves the last stage as one word.
//   All stages advance together whenever the output slot is empty or is being
//   consumed. Backpressure therefore freezes the whole pipe.
// Ports
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   IN_VALID   operands valid            IN_READY   operation accepted this cycle
//   A, B       operands                  SUB        1: A-B, 0: A+B
//   SIGNED     1: OVF is signed overflow, 0: OVF is unsigned carry/borrow
//   OUT_VALID  result valid              OUT_READY  downstream accepts result
//   OUT        result modulo 2^WIDTH     COUT       carry out (SUB: 1 = no borrow)
//   OVF        overflow flag
module pipe_addsub_nbit #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic             SIGNED,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             COUT,
  output logic             OVF
);
  localparam int STAGES = WIDTH / SEG_W;
  localparam int LAST   = STAGES - 1;

  if (WIDTH < 2) begin : g_chk_width
    $error("pipe_addsub_nbit: WIDTH must be at least 2");
  end
  if (SEG_W < 1) begin : g_chk_seg
    $error("pipe_addsub_nbit: SEG_W must be at least 1");
  end else if (WIDTH % SEG_W != 0) begin : g_chk_seg
    $error("pipe_addsub_nbit: WIDTH must be a multiple of SEG_W");
  end

  // One segment of the carry chain: {carry_out, sum}.
  function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] x,
                                             input logic [SEG_W-1:0] y,
                                             input logic             cin);
    return {1'b0, x} + {1'b0, y} + {{SEG_W{1'b0}}, cin};
  endfunction

  // Overflow from the operand MSBs (B already conditionally inverted).
  function automatic logic ovf_calc(input logic sgn, input logic sub,
                                    input logic a_msb, input logic b_msb,
                                    input logic r_msb, input logic cout);
    if (sgn) return (a_msb == b_msb) && (r_msb != a_msb);
    return sub ? ~cout : cout;
  endfunction

  logic adv;
  assign adv      = ~OUT_VALID | OUT_READY;
  assign IN_READY = adv;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stg
    // UW: operand bits still unresolved on entry; RW: result bits resolved here.
    localparam int UW = WIDTH - k * SEG_W;
    localparam int RW = (k + 1) * SEG_W;

    logic          v_in, c_in, s_in, g_in;
    logic [UW-1:0] a_in, b_in;
    logic [SEG_W:0] sum;
    logic [RW-1:0] r_new;
    logic          vld_q, vld_d, c_q, c_d;
    logic [RW-1:0] r_q, r_d;

    if (k == 0) begin : g_src
      assign v_in  = IN_VALID;
      assign c_in  = SUB;
      assign s_in  = SUB;
      assign g_in  = SIGNED;
      assign a_in  = A;
      assign b_in  = SUB ? ~B : B;
      assign r_new = sum[SEG_W-1:0];
    end else begin : g_src
      assign v_in  = g_stg[k-1].vld_q;
      assign c_in  = g_stg[k-1].c_q;
      assign s_in  = g_stg[k-1].g_skew.sub_q;
      assign g_in  = g_stg[k-1].g_skew.sgn_q;
      assign a_in  = g_stg[k-1].g_skew.a_q;
      assign b_in  = g_stg[k-1].g_skew.b_q;
      assign r_new = {sum[SEG_W-1:0], g_stg[k-1].r_q};
    end

    assign sum = seg_add(a_in[SEG_W-1:0], b_in[SEG_W-1:0], c_in);

    always_comb begin
      vld_d = vld_q;
      c_d   = c_q;
      r_d   = r_q;
      if (adv) begin
        vld_d = v_in;
        c_d   = sum[SEG_W];
        r_d   = r_new;
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        r_q   <= '0;
      end else begin
        vld_q <= vld_d;
        c_q   <= c_d;
        r_q   <= r_d;
      end
    end

    if (k < LAST) begin : g_skew
      // Upper operand segments and the mode bits travel with the operation.
      logic [UW-SEG_W-1:0] a_q, a_d, b_q, b_d;
      logic                sub_q, sub_d, sgn_q, sgn_d;

      always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        sub_d = sub_q;
        sgn_d = sgn_q;
        if (adv) begin
          a_d   = a_in[UW-1:SEG_W];
          b_d   = b_in[UW-1:SEG_W];
          sub_d = s_in;
          sgn_d = g_in;
        end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
          sgn_q <= 1'b0;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          sub_q <= sub_d;
          sgn_q <= sgn_d;
        end
      end
    end else begin : g_tail
      // The top segment holds the operand MSBs, so overflow is settled here.
      logic ovf_q, ovf_d;

      always_comb begin
        ovf_d = ovf_q;
        if (adv) begin
          ovf_d = ovf_calc(g_in, s_in, a_in[UW-1], b_in[UW-1],
                           sum[SEG_W-1], sum[SEG_W]);
        end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
      end
    end
  end

  assign OUT_VALID = g_stg[LAST].vld_q;
  assign OUT       = g_stg[LAST].r_q;
  assign COUT      = g_stg[LAST].c_q;
  assign OVF       = g_stg[LAST].g_tail.ovf_q;

endmodule
